// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: word size, bubble word,
// fetch FSM encoding and the branch-target-buffer entry layout.
package inst_fetch_unit_pkg;

   localparam int unsigned WORD_SIZE   = 16;
   localparam int unsigned BTB_INDEX_W = 2;
   localparam int unsigned BTB_TAG_W   = WORD_SIZE - BTB_INDEX_W;
   localparam int unsigned BTB_ENTRIES = 1 << BTB_INDEX_W;

   // Word presented to decode whenever nothing valid is available.
   localparam logic [WORD_SIZE-1:0] NOP_INST = 16'hB000;

   typedef enum logic [1:0] {
      StFetch,
      StHold,
      StDiscard,
      StHalt
   } fetch_state_e;

   typedef struct packed {
      logic                 valid;
      logic [BTB_TAG_W-1:0] tag;
      logic [WORD_SIZE-1:0] target;
   } btb_entry_t;

   function automatic logic [BTB_INDEX_W-1:0] btb_index(input logic [WORD_SIZE-1:0] pc);
      return pc[BTB_INDEX_W-1:0];
   endfunction

   function automatic logic [BTB_TAG_W-1:0] btb_tag(input logic [WORD_SIZE-1:0] pc);
      return pc[WORD_SIZE-1:BTB_INDEX_W];
   endfunction

endpackage

// File: rtl/inst_fetch_unit_btb.sv
// fetch_btb: 4-entry direct-mapped branch target buffer. Lookup is combinational
// from the stored table, so a write on the same edge is seen only afterwards.
module fetch_btb
   import inst_fetch_unit_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WORD_SIZE-1:0] lookup_pc,
   output logic                 hit,
   output logic [WORD_SIZE-1:0] hit_target,
   input  logic                 upd_en,
   input  logic [WORD_SIZE-1:0] upd_pc,
   input  logic [WORD_SIZE-1:0] upd_target
);

   btb_entry_t entries_q [BTB_ENTRIES];
   btb_entry_t rd_entry;

   // Lookup: index by the low address bits, compare the remaining bits as tag.
   always_comb begin
      rd_entry   = entries_q[btb_index(lookup_pc)];
      hit        = rd_entry.valid && (rd_entry.tag == btb_tag(lookup_pc));
      hit_target = rd_entry.target;
   end

   // Training writes one entry; reset invalidates the whole table.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
            entries_q[i] <= '0;
         end
      end else if (upd_en) begin
         entries_q[btb_index(upd_pc)] <= {1'b1, btb_tag(upd_pc), upd_target};
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: single-outstanding-request instruction fetch with a one-word
// stall buffer, redirect/discard handling and halt. Define BRANCH_TARGET_BUFFER_EN
// to add the fetch_btb predictor for the next fetch address.
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   output logic                 i_readM,
   output logic [WORD_SIZE-1:0] i_address,
   input  logic [WORD_SIZE-1:0] i_data,
   input  logic                 i_ready,
   input  logic                 IF_ID_Write,
   input  logic                 Redirect,
   input  logic [WORD_SIZE-1:0] RedirectTarget,
   input  logic                 IsHalted,
   input  logic                 BtbUpdate,
   input  logic [WORD_SIZE-1:0] BtbUpdPc,
   input  logic [WORD_SIZE-1:0] BtbUpdTarget,
   output logic [WORD_SIZE-1:0] Pc,
   output logic [WORD_SIZE-1:0] inst,
   output logic                 InstValid
);

   fetch_state_e         state_q;
   logic [WORD_SIZE-1:0] fetch_pc_q;
   logic [WORD_SIZE-1:0] req_addr_q;  // address of the request being discarded
   logic [WORD_SIZE-1:0] pc_q;        // last presented Pc, shown while nothing is valid
   logic [WORD_SIZE-1:0] buf_q;
   logic [WORD_SIZE-1:0] pc_plus1;
   logic [WORD_SIZE-1:0] next_pc;

   assign pc_plus1 = fetch_pc_q + 16'd1;

`ifdef BRANCH_TARGET_BUFFER_EN
   logic                 btb_hit;
   logic [WORD_SIZE-1:0] btb_target;

   fetch_btb u_btb (
      .clk        (clk),
      .reset_n    (reset_n),
      .lookup_pc  (fetch_pc_q),
      .hit        (btb_hit),
      .hit_target (btb_target),
      .upd_en     (BtbUpdate),
      .upd_pc     (BtbUpdPc),
      .upd_target (BtbUpdTarget)
   );

   assign next_pc = btb_hit ? btb_target : pc_plus1;
`else
   logic unused_btb;
   assign unused_btb = ^{BtbUpdate, BtbUpdPc, BtbUpdTarget};
   assign next_pc    = pc_plus1;
`endif

   // Outputs: request and presentation follow the state; reset_n low masks both.
   always_comb begin
      i_readM   = 1'b0;
      i_address = fetch_pc_q;
      InstValid = 1'b0;
      inst      = NOP_INST;
      Pc        = pc_q;
      if (reset_n) begin
         unique case (state_q)
            StFetch: begin
               i_readM = 1'b1;
               if (i_ready && !Redirect && !IsHalted) begin
                  InstValid = 1'b1;
                  inst      = i_data;
                  Pc        = pc_plus1;
               end
            end
            StHold: begin
               if (!Redirect && !IsHalted) begin
                  InstValid = 1'b1;
                  inst      = buf_q;
                  Pc        = pc_plus1;
               end
            end
            StDiscard: begin
               i_readM   = 1'b1;
               i_address = req_addr_q;
            end
            StHalt: ;
         endcase
      end
   end

   // Fetch FSM: Redirect wins over halt, halt over the normal fetch/hold flow.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= StFetch;
         fetch_pc_q <= '0;
         req_addr_q <= '0;
         pc_q       <= '0;
         buf_q      <= NOP_INST;
      end else begin
         if (InstValid) pc_q <= Pc;
         unique case (state_q)
            StFetch: begin
               if (Redirect) begin
                  fetch_pc_q <= RedirectTarget;
                  req_addr_q <= fetch_pc_q;
                  state_q    <= i_ready ? StFetch : StDiscard;
               end else if (IsHalted) begin
                  if (i_ready) state_q <= StHalt;
               end else if (i_ready) begin
                  if (IF_ID_Write) begin
                     fetch_pc_q <= next_pc;
                  end else begin
                     buf_q   <= i_data;
                     state_q <= StHold;
                  end
               end
            end
            StHold: begin
               if (Redirect) begin
                  fetch_pc_q <= RedirectTarget;
                  state_q    <= StFetch;
               end else if (IsHalted) begin
                  state_q <= StHalt;
               end else if (IF_ID_Write) begin
                  fetch_pc_q <= next_pc;
                  state_q    <= StFetch;
               end
            end
            StDiscard: begin
               // The stale response is swallowed; a newer redirect just retargets.
               if (Redirect) fetch_pc_q <= RedirectTarget;
               if (i_ready)  state_q    <= StFetch;
            end
            StHalt: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural fetch model.
module tb_inst_fetch_unit;
   import inst_fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_readM;
   logic [15:0] i_address;
   logic [15:0] i_data = 16'h0;
   logic        i_ready = 1'b0;
   logic        IF_ID_Write = 1'b1;
   logic        Redirect = 1'b0;
   logic [15:0] RedirectTarget = 16'h0;
   logic        IsHalted = 1'b0;
   logic        BtbUpdate = 1'b0;
   logic [15:0] BtbUpdPc = 16'h0;
   logic [15:0] BtbUpdTarget = 16'h0;
   logic [15:0] Pc;
   logic [15:0] inst;
   logic        InstValid;

   always #5 clk = ~clk;

   inst_fetch_unit dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .i_readM        (i_readM),
      .i_address      (i_address),
      .i_data         (i_data),
      .i_ready        (i_ready),
      .IF_ID_Write    (IF_ID_Write),
      .Redirect       (Redirect),
      .RedirectTarget (RedirectTarget),
      .IsHalted       (IsHalted),
      .BtbUpdate      (BtbUpdate),
      .BtbUpdPc       (BtbUpdPc),
      .BtbUpdTarget   (BtbUpdTarget),
      .Pc             (Pc),
      .inst           (inst),
      .InstValid      (InstValid)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: where the next fetch goes, whether a stale response is
   // still owed, the stalled word (queue of at most one) and whether we halted.
   logic [15:0] m_pc = 16'h0;
   logic        m_drop = 1'b0;
   logic [15:0] m_drop_addr = 16'h0;
   logic        m_halted = 1'b0;
   logic [15:0] m_held[$];
`ifdef BRANCH_TARGET_BUFFER_EN
   logic        bt_valid[4];
   logic [15:0] bt_pc[4];
   logic [15:0] bt_tgt[4];
`endif

   logic        o_readM, o_valid;
   logic [15:0] o_addr, o_inst, o_pc;

   function automatic logic [15:0] predict(input logic [15:0] pc);
`ifdef BRANCH_TARGET_BUFFER_EN
      int idx = int'(pc[1:0]);
      if (bt_valid[idx] && bt_pc[idx] == pc) return bt_tgt[idx];
`endif
      return pc + 16'd1;
   endfunction

   task automatic step(input logic rst, input logic rdy, input logic [15:0] data,
                       input logic ifid, input logic redir, input logic [15:0] tgt,
                       input logic halt, input logic bupd, input logic [15:0] bpc,
                       input logic [15:0] btgt);
      logic        e_readM, e_valid, chk_nop;
      logic [15:0] e_addr, e_inst, e_pc, nxt;
      @(negedge clk);
      reset_n = rst; i_ready = rdy; i_data = data; IF_ID_Write = ifid;
      Redirect = redir; RedirectTarget = tgt; IsHalted = halt;
      BtbUpdate = bupd; BtbUpdPc = bpc; BtbUpdTarget = btgt;
      #1;
      o_readM = i_readM; o_addr = i_address; o_valid = InstValid; o_inst = inst; o_pc = Pc;
      e_readM = 1'b0; e_valid = 1'b0; e_addr = m_pc; e_inst = NOP_INST; e_pc = 16'h0;
      chk_nop = 1'b0;
      if (!rst) begin
         chk_nop = 1'b1;
      end else if (m_halted) begin
         chk_nop = 1'b0;
      end else if (m_held.size() != 0) begin
         e_valid = !redir && !halt;
         e_inst  = m_held[0];
         e_pc    = m_pc + 16'd1;
      end else begin
         e_readM = 1'b1;
         if (m_drop) begin
            e_addr = m_drop_addr;
         end else begin
            e_valid = rdy && !redir && !halt;
            e_inst  = data;
            e_pc    = m_pc + 16'd1;
            chk_nop = !rdy;
         end
      end
      check_eq("i_readM", {15'h0, o_readM}, {15'h0, e_readM});
      if (e_readM) check_eq("i_address", o_addr, e_addr);
      check_eq("InstValid", {15'h0, o_valid}, {15'h0, e_valid});
      if (e_valid) begin
         check_eq("inst", o_inst, e_inst);
         check_eq("Pc", o_pc, e_pc);
      end else if (chk_nop) begin
         check_eq("inst_nop", o_inst, NOP_INST);
      end
      @(posedge clk);
      if (!rst) begin
         m_pc = 16'h0; m_drop = 1'b0; m_halted = 1'b0; m_held.delete();
`ifdef BRANCH_TARGET_BUFFER_EN
         for (int i = 0; i < 4; i++) bt_valid[i] = 1'b0;
`endif
      end else begin
         nxt = predict(m_pc);
         if (m_halted) begin
            m_halted = 1'b1;
         end else if (redir) begin
            if (m_held.size() != 0) begin
               m_held.delete();
            end else if (!rdy) begin
               if (!m_drop) m_drop_addr = m_pc;
               m_drop = 1'b1;
            end else begin
               m_drop = 1'b0;
            end
            m_pc = tgt;
         end else if (m_drop) begin
            if (rdy) m_drop = 1'b0;
         end else if (halt) begin
            if (m_held.size() != 0 || rdy) begin
               m_halted = 1'b1;
               m_held.delete();
            end
         end else if (m_held.size() != 0) begin
            if (ifid) begin
               m_held.delete();
               m_pc = nxt;
            end
         end else if (rdy) begin
            if (ifid) m_pc = nxt;
            else m_held.push_back(data);
         end
`ifdef BRANCH_TARGET_BUFFER_EN
         if (bupd) begin
            bt_valid[int'(bpc[1:0])] = 1'b1;
            bt_pc[int'(bpc[1:0])]    = bpc;
            bt_tgt[int'(bpc[1:0])]   = btgt;
         end
`endif
      end
   endtask

   task automatic cyc(input logic rdy, input logic [15:0] data, input logic ifid,
                      input logic redir, input logic [15:0] tgt, input logic halt);
      step(1'b1, rdy, data, ifid, redir, tgt, halt, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   initial begin
      // Reset state, then back-to-back fetches.
      do_reset();
      do_reset();
      check_eq("rst_readM", {15'h0, o_readM}, 16'h0);
      check_eq("rst_valid", {15'h0, o_valid}, 16'h0);
      check_eq("rst_inst", o_inst, NOP_INST);
      check_eq("rst_pc", o_pc, 16'h0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 16'hA000 + 16'(i), 1'b1, 1'b0, 16'h0, 1'b0);
         check_eq("seq_addr", o_addr, 16'(i));
         check_eq("seq_pc", o_pc, 16'(i + 1));
         check_eq("seq_valid", {15'h0, o_valid}, 16'h1);
      end

      // Cache wait states at address 5.
      cyc(1'b1, 16'hA004, 1'b1, 1'b0, 16'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 16'hDEAD, 1'b1, 1'b0, 16'h0, 1'b0);
         check_eq("wait_addr", o_addr, 16'h5);
         check_eq("wait_valid", {15'h0, o_valid}, 16'h0);
      end
      cyc(1'b1, 16'hA005, 1'b1, 1'b0, 16'h0, 1'b0);
      check_eq("wait_pc", o_pc, 16'h6);

      // Decode stall: word held for three cycles, no request meanwhile.
      cyc(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0, 1'b0);
      check_eq("hold_inst0", o_inst, 16'h1234);
      cyc(1'b1, 16'h5678, 1'b0, 1'b0, 16'h0, 1'b0);
      check_eq("hold_inst1", o_inst, 16'h1234);
      check_eq("hold_readM1", {15'h0, o_readM}, 16'h0);
      cyc(1'b1, 16'h5678, 1'b1, 1'b0, 16'h0, 1'b0);
      check_eq("hold_inst2", o_inst, 16'h1234);
      check_eq("hold_readM2", {15'h0, o_readM}, 16'h0);
      cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
      check_eq("hold_next_addr", o_addr, 16'h7);

      // Redirect while the request at 7 is pending.
      cyc(1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, 1'b0);
      check_eq("redir_valid", {15'h0, o_valid}, 16'h0);
      cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
      check_eq("disc_addr", o_addr, 16'h7);
      cyc(1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0, 1'b0);
      check_eq("disc_valid", {15'h0, o_valid}, 16'h0);
      cyc(1'b1, 16'h5555, 1'b1, 1'b0, 16'h0, 1'b0);
      check_eq("redir_addr", o_addr, 16'h0040);
      check_eq("redir_pc", o_pc, 16'h0041);

      // Same-cycle redirect with ready, wrap at 16'hFFFF, then halt.
      cyc(1'b1, 16'hBEEF, 1'b1, 1'b1, 16'hFFFF, 1'b0);
      check_eq("redir_rdy_valid", {15'h0, o_valid}, 16'h0);
      cyc(1'b1, 16'h7777, 1'b1, 1'b0, 16'h0, 1'b0);
      check_eq("wrap_addr", o_addr, 16'hFFFF);
      check_eq("wrap_pc", o_pc, 16'h0000);
      cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1);
      check_eq("wrap_next_addr", o_addr, 16'h0000);
      cyc(1'b1, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 16'h1111, 1'b1, 1'b0, 16'h0, 1'b0);
         check_eq("halt_readM", {15'h0, o_readM}, 16'h0);
         check_eq("halt_valid", {15'h0, o_valid}, 16'h0);
      end

`ifdef BRANCH_TARGET_BUFFER_EN
      // Train 0x10 -> 0x30, then fetch 0x10.
      do_reset();
      step(1'b1, 1'b1, 16'h0, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b1, 16'h0010, 16'h0030);
      cyc(1'b1, 16'h2222, 1'b1, 1'b0, 16'h0, 1'b0);
      check_eq("btb_fetch_addr", o_addr, 16'h0010);
      cyc(1'b1, 16'h3333, 1'b1, 1'b0, 16'h0, 1'b0);
      check_eq("btb_pred_addr", o_addr, 16'h0030);
`endif

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 99) >= 3,
              $urandom_range(0, 9) < 7,
              16'($urandom),
              $urandom_range(0, 9) < 8,
              $urandom_range(0, 9) < 1,
              16'($urandom_range(0, 63)),
              $urandom_range(0, 99) < 1,
              $urandom_range(0, 9) < 2,
              16'($urandom_range(0, 63)),
              16'($urandom_range(0, 63)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL provide ports (name  direction  width  meaning):
- clk  in  1  sole clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- i_readM  out  1  instruction-cache read request.
- i_address  out  16  word address of the request.
- i_data  in  16  instruction word; valid only while i_ready=1.
- i_ready  in  1  cache completes the outstanding request this cycle.
- IF_ID_Write  in  1  0 = decode stalled; the presented instruction is held.
- Redirect  in  1  control transfer resolved in decode.
- RedirectTarget  in  16  new fetch address; sampled when Redirect=1.
- IsHalted  in  1  HLT decoded; stop fetching.
- BtbUpdate  in  1  BTB training strobe.
- BtbUpdPc  in  16  branch address being trained.
- BtbUpdTarget  in  16  taken target being trained.
- Pc  out  16  address of the presented instruction + 1.
- inst  out  16  presented instruction word.
- InstValid  out  1  Pc and inst are meaningful.

Function
REQ-002 SHALL implement the states FETCH, HOLD, DISCARD and HALT.
REQ-003 In FETCH the block SHALL drive i_readM=1 and i_address=FetchPc, holding both stable until i_ready=1.
REQ-004 On FETCH with i_ready=1 and IF_ID_Write=1, the block SHALL present {FetchPc+1, i_data} with InstValid=1 in the same cycle and SHALL advance FetchPc to NextPc.
REQ-005 On FETCH with i_ready=1 and IF_ID_Write=0, the block SHALL latch i_data into a one-entry buffer and go to HOLD.
REQ-006 In HOLD the block SHALL keep i_readM=0, present the buffered word with InstValid=1, and return to FETCH with FetchPc=NextPc on the first cycle in which IF_ID_Write=1.
REQ-007 In FETCH with i_ready=0, the block SHALL drive InstValid=0 and inst=NOP_INST.
REQ-008 NextPc SHALL be FetchPc+1 computed modulo 2^16, so 16'hFFFF wraps to 16'h0000.
REQ-009 When Redirect=1, the block SHALL set FetchPc=RedirectTarget, drop any buffered word, and drive InstValid=0 in that cycle.
REQ-010 If Redirect=1 arrives while a request is outstanding and i_ready=0, the block SHALL go to DISCARD. In DISCARD it SHALL keep the request asserted, ignore i_data when i_ready=1, and then enter FETCH at the redirect target.
REQ-011 If Redirect=1 and i_ready=1 occur in the same cycle, the block SHALL discard i_data and fetch RedirectTarget on the next cycle.
REQ-012 Redirect SHALL take priority over IF_ID_Write=0 and over IsHalted.
REQ-013 IsHalted=1 with Redirect=0 SHALL move the block to HALT once no request is outstanding. HALT SHALL hold i_readM=0 and InstValid=0 until reset.
REQ-014 Throughput SHALL be one instruction per cycle when i_ready=1 in consecutive cycles.

Reset
REQ-015 When reset_n=0 at a clk edge, the block SHALL set the state to FETCH, FetchPc=0, Pc=0, inst=NOP_INST, InstValid=0, i_readM=0 and empty the buffer, with the BTB cleared if present.
REQ-016 Reset SHALL abandon any outstanding or discarded request. The first request SHALL issue in the cycle after reset_n returns to 1.

Configuration
REQ-017 With BRANCH_TARGET_BUFFER_EN defined, the block SHALL include a 4-entry direct-mapped BTB with {valid, tag=Pc[15:2], target} per entry, indexed by Pc[1:0].
- On a hit, NextPc SHALL be the stored target.
- BtbUpdate=1 SHALL write its entry on the next edge.
- A simultaneous lookup on the same entry SHALL see the old contents.
REQ-018 Without BRANCH_TARGET_BUFFER_EN, NextPc SHALL always be FetchPc+1, BtbUpdate, BtbUpdPc and BtbUpdTarget SHALL be ignored, and no BTB storage SHALL exist.

Structure
REQ-019 The shared package SHALL hold WORD_SIZE=16, NOP_INST, the fetch-state encoding and the BTB entry typedef.
REQ-020 The BTB SHALL be the sub-module fetch_btb, instantiated only under BRANCH_TARGET_BUFFER_EN.

Verification
REQ-021 The bench SHALL cover at least these directed scenarios:
- Reset, then i_ready=1 every cycle: i_address runs 0,1,2,3; Pc runs 1,2,3,4 with InstValid=1 each cycle.
- i_ready delayed 3 cycles at address 5: i_address stays 5, InstValid=0 for 3 cycles, then Pc=6.
- IF_ID_Write=0 for 2 cycles when i_ready=1 with i_data=16'h1234: inst holds 16'h1234 for 3 cycles, i_readM=0 during HOLD, and the next request is FetchPc+1.
- Redirect to 16'h0040 while the request at 7 is pending: the word for 7 is dropped, the next i_address is 16'h0040, and it is never presented.
- FetchPc=16'hFFFF: the next i_address is 16'h0000; IsHalted=1 leads to HALT with i_readM=0 for 10 or more cycles.
- With BRANCH_TARGET_BUFFER_EN, train 16'h0010 to 16'h0030, then fetch 16'h0010: the next i_address is 16'h0030.
